// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-stage hazard unit bus; perf ports exist only with HAZARD_PERF_CNT_EN
interface hazard_scoreboard_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             ifid_use1;
  logic             ifid_use2;
  logic             idex_valid;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_rd;
  logic             mem_busy;
  logic             flush;
  logic             stall;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic [1:0]       stall_cause;
`ifdef HAZARD_PERF_CNT_EN
  logic             perf_clr;
  logic [CNT_W-1:0] ldu_stall_cnt;
  logic [CNT_W-1:0] memb_stall_cnt;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_use1, ifid_use2, idex_valid, idex_mem_read, idex_rd,
           mem_busy, flush, perf_clr,
    input  stall, pc_write_en, ifid_write_en, stall_cause, ldu_stall_cnt, memb_stall_cnt
  );
  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_use1, ifid_use2, idex_valid, idex_mem_read, idex_rd,
           mem_busy, flush, perf_clr,
    output stall, pc_write_en, ifid_write_en, stall_cause, ldu_stall_cnt, memb_stall_cnt
  );
`else
  modport master (
    output ifid_rs1, ifid_rs2, ifid_use1, ifid_use2, idex_valid, idex_mem_read, idex_rd,
           mem_busy, flush,
    input  stall, pc_write_en, ifid_write_en, stall_cause
  );
  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_use1, ifid_use2, idex_valid, idex_mem_read, idex_rd,
           mem_busy, flush,
    output stall, pc_write_en, ifid_write_en, stall_cause
  );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - multi-cycle load-use hazard scoreboard with memory-busy freeze
// Optional stall performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] LDUSE = 2'd1;
  localparam logic [1:0] MEMB  = 2'd2;
  localparam logic [2:0] LOAD_INIT = 3'(LOAD_LAT - 1);

  logic [2:0] pend [NUM_REGS];
  logic [1:0] state;
  logic [1:0] stateNext;
  logic       exLoad;
  logic       useHit;
  logic       ldStall;

  // Indices at or above NUM_REGS fall out of the loop and never hit a counter.
  function automatic logic pendHit(input logic [REG_W-1:0] r);
    pendHit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (r == REG_W'(i) && pend[i] != 3'd0) pendHit = 1'b1;
  endfunction

  assign exLoad = bus.idex_valid & bus.idex_mem_read;
  assign useHit = (bus.ifid_use1 & ((exLoad & (bus.idex_rd == bus.ifid_rs1)) | pendHit(bus.ifid_rs1)))
                | (bus.ifid_use2 & ((exLoad & (bus.idex_rd == bus.ifid_rs2)) | pendHit(bus.ifid_rs2)));
  assign ldStall = useHit & ~bus.flush;

  // Reset overrides the combinational hit so a load still sitting in ID/EX cannot stall.
  assign bus.stall         = rst & ~bus.mem_busy & ldStall;
  assign bus.pc_write_en   = ~rst | (~bus.mem_busy & ~ldStall);
  assign bus.ifid_write_en = ~rst | (~bus.mem_busy & ~ldStall);
  assign bus.stall_cause   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) pend[i] <= 3'd0;
    end else if (!bus.mem_busy) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (exLoad && !bus.flush && bus.idex_rd == REG_W'(i))
          pend[i] <= LOAD_INIT;
        else if (pend[i] != 3'd0)
          pend[i] <= pend[i] - 3'd1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (bus.mem_busy) begin
      stateNext = MEMB;
    end else begin
      case (state)
        RUN:     if (ldStall) stateNext = LDUSE;
        LDUSE:   if (!useHit) stateNext = RUN;
        MEMB:    stateNext = ldStall ? LDUSE : RUN;
        default: stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= stateNext;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lduCnt;
  logic [CNT_W-1:0] membCnt;

  // Counters saturate rather than wrap; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lduCnt  <= '0;
      membCnt <= '0;
    end else if (bus.perf_clr) begin
      lduCnt  <= '0;
      membCnt <= '0;
    end else begin
      if (state == LDUSE && !(&lduCnt))  lduCnt  <= lduCnt + CNT_W'(1);
      if (state == MEMB  && !(&membCnt)) membCnt <= membCnt + CNT_W'(1);
    end
  end

  assign bus.ldu_stall_cnt  = lduCnt;
  assign bus.memb_stall_cnt = membCnt;
`else
  if (CNT_W > 0) begin : gNoPerfCnt
  end
`endif
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised load-use hazard unit for the 5-stage pipeline, successor to the single-cycle load-use detector.
- Tracks outstanding loads per architectural register with countdown counters, so memory latency (LOAD_LAT) is configurable.
- Freezes the pipeline on a memory-busy signal and suppresses stalls on a flush.
- Sits in the decode stage and drives the PC/IF-ID write enables and the ID/EX bubble select.

Parameters:
- NUM_REGS, 8, number of architectural registers (one counter each).
- REG_W, 3, register-specifier width; NUM_REGS <= 2**REG_W.
- LOAD_LAT, 1, cycles from a load in EX until its data is forwardable; legal range 1..8.
- CNT_W, 16, stall performance counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ifid_rs1  in  REG_W  first source register of the instruction in IF/ID.
- ifid_rs2  in  REG_W  second source register of the instruction in IF/ID.
- ifid_use1  in  1  IF/ID instruction reads rs1.
- ifid_use2  in  1  IF/ID instruction reads rs2.
- idex_valid  in  1  ID/EX holds a real instruction (not a bubble).
- idex_mem_read  in  1  ID/EX instruction is a load.
- idex_rd  in  REG_W  ID/EX destination register.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- flush  in  1  branch/jump redirect; IF/ID and ID/EX are being squashed this cycle.
- stall  out  1  insert bubble into ID/EX.
- pc_write_en  out  1  PC may update.
- ifid_write_en  out  1  IF/ID may update.
- stall_cause  out  2  0 none, 1 load-use, 2 memory busy (registered state, see FSM).

Behaviour:
- Scoreboard: pend[r], width 3, one per register, all reset to 0.
- Combinational hit:
  - use_hit = (ifid_use1 & (match(ifid_rs1))) | (ifid_use2 & (match(ifid_rs2))).
  - match(x) = (idex_valid & idex_mem_read & idex_rd==x) | (pend[x] != 0).
- Freeze = mem_busy. While frozen:
  - pend values hold.
  - pc_write_en = ifid_write_en = 0.
  - stall = 0 (ID/EX also holds; no bubble).
- Otherwise:
  - stall = use_hit & ~flush.
  - pc_write_en = ifid_write_en = ~stall.
- Counter update at posedge clk, when not frozen:
  - If idex_valid & idex_mem_read & ~flush, pend[idex_rd] <= LOAD_LAT-1.
  - Every other nonzero pend decrements by 1.
  - If a load targets a register whose counter is also decrementing, the load value wins.
- LOAD_LAT=1: counters never become nonzero; behaviour is exactly one bubble per load-use pair.
- LOAD_LAT=N: a dependent instruction directly behind a load gets N bubbles.
- Flush does not clear pend; loads already past EX still complete.
- FSM (registered, drives stall_cause):
  - RUN(0) -> LDUSE(1) when stall and not frozen.
  - any -> MEMB(2) when mem_busy.
  - LDUSE -> RUN when use_hit clears.
  - MEMB -> LDUSE if mem_busy falls with use_hit & ~flush, else RUN.
  - mem_busy has priority over load-use.
- Reset (rst=0, asynchronous):
  - All pend = 0, FSM = RUN.
  - Outputs forced to stall=0, pc_write_en=1, ifid_write_en=1, stall_cause=0 regardless of inputs.
  - Reset mid-stall abandons the stall immediately.
- Out-of-range register index (>= NUM_REGS) never matches a counter; it is still compared against idex_rd.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs ldu_stall_cnt[CNT_W] and memb_stall_cnt[CNT_W], both reset to 0.
  - Each increments once per cycle spent in LDUSE or MEMB respectively.
  - Each saturates at all-ones (no wrap).
  - Adds input perf_clr, which synchronously zeroes both counters; perf_clr has priority over increment.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- LOAD_LAT=1: load r3 in ID/EX, IF/ID uses rs1=3 -> stall=1, pc_write_en=0 for exactly 1 cycle, stall_cause=1 the following cycle; then stall=0.
- LOAD_LAT=3: load r5, then dependent add using rs2=5 -> 3 consecutive stall cycles; independent instruction (rs=2) -> 0 stalls.
- mem_busy=1 for 4 cycles while pend[5]=2 -> outputs frozen (stall=0, write enables 0), pend[5] stays 2, stall_cause=2; after release, the remaining 2 stall cycles occur.
- Load-use match with flush=1 -> stall=0; load not recorded (pend[rd]=0 next cycle).
- Assert rst low mid LDUSE with LOAD_LAT=4 -> immediately stall=0, enables 1, all pend=0 after release.
- HAZARD_PERF_CNT_EN with CNT_W=2: 5 load-use stall cycles -> ldu_stall_cnt saturates at 3; perf_clr -> 0.
